// File: rtl/coriolis_stream_sink_pkg.sv
// Shared constants for the coriolis stream sink and its FIFO.
// Holds the stream word width, the flopoco exception-field encoding and the
// default slack derived from the deepest kernel pipeline.
package coriolis_stream_sink_pkg;

  // 32-bit float plus the 2-bit flopoco exception field, carried opaquely.
  localparam int STREAMW_DEF = 34;

  // flopoco exception field value for an ordinary (normal) number.
  localparam logic [1:0] FLOPOCO_EXC_NORMAL = 2'b01;

  // Deepest kernel pipeline is FPAdd; that many results can still be in
  // flight after iready drops.
  localparam int FPADD_LATENCY = 8;
  localparam int SLACK_DEF     = FPADD_LATENCY;

endpackage

// File: rtl/coriolis_fwft_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy.
// Ports: push/push_dat (caller guarantees space or a same-cycle pop),
//        pop/pop_dat (pop_dat is the head, valid whenever !empty), full/empty/occ.
module coriolis_fwft_fifo
  import coriolis_stream_sink_pkg::*;
#(
  parameter int W     = STREAMW_DEF,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   occ
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by occ_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = (occ_q == (AW+1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign occ     = occ_q;

endmodule

// File: rtl/coriolis_stream_sink.sv
// Terminating sink for a kernel output stream: FWFT buffer, slack-based ready, result counter.
// Ports: ivalid/in1/iready from the kernel, ovalid/out1/oready toward the writer,
//        count/done/overflow status; rst is asynchronous active-low.
module coriolis_stream_sink
  import coriolis_stream_sink_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int SLACK   = SLACK_DEF,
  parameter int NELEM   = 1024,
  parameter int CW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid,
  input  logic [STREAMW-1:0] in1,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  input  logic               oready,
  output logic [CW-1:0]      count,
  output logic               done,
  output logic               overflow
);

  // Ready stays high only while more than SLACK slots would remain free,
  // i.e. occupancy strictly below DEPTH-SLACK.
  localparam logic [AW:0] OCC_THRESH = (AW+1)'(DEPTH - SLACK);

  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_occ, occ_next;
  logic          push, pop;
  logic          iready_q, iready_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;

  // iready is advisory: a word is taken whenever a slot exists, including
  // the slot a same-cycle pop frees.
  assign pop  = !fifo_empty && oready;
  assign push = ivalid && (!fifo_full || pop);

  always_comb begin
    occ_next   = fifo_occ + (AW+1)'(push) - (AW+1)'(pop);
    iready_d   = (occ_next < OCC_THRESH);
    count_d    = (pop && (count_q != '1)) ? count_q + 1'b1 : count_q;
    done_d     = done_q || ((count_d == CW'(NELEM)) && (count_q != count_d));
    overflow_d = overflow_q || (ivalid && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iready_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      iready_q   <= iready_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  coriolis_fwft_fifo #(
    .W     (STREAMW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push),
    .push_dat (in1),
    .pop      (pop),
    .pop_dat  (out1),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occ      (fifo_occ)
  );

  assign ovalid   = !fifo_empty;
  assign iready   = iready_q;
  assign count    = count_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/coriolis_stream_sink.md
Name: coriolis_stream_sink

Overview:
- Terminating end of a kernel output stream. It accepts the valid/data stream that a leaf or compound map node emits on its ovalid/out1 ports.
- It drives the upstream oready through a registered, occupancy-based slack threshold. Upstream pipelines may therefore keep delivering in-flight results after ready drops without losing data.
- Buffers results in a first-word-fall-through (FWFT) FIFO toward the host or memory writer, and counts results to flag completion of an NELEM-element work-item.

Parameters:
- STREAMW, 34, data width (32-bit float plus 2-bit flopoco exception field); carried opaquely.
- DEPTH, 16, FIFO depth in words; power of two, at least 2*SLACK.
- AW, 4, log2(DEPTH).
- SLACK, 8, maximum upstream pipeline latency; words that may still arrive after iready deasserts.
- NELEM, 1024, results per work-item; done threshold.
- CW, 16, width of the element counters.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- ivalid, in, 1, upstream result valid; connects to the kernel's ovalid.
- in1, in, STREAMW, upstream result data; connects to the kernel's out1.
- iready, out, 1, ready to upstream; connects to the kernel's oready.
- ovalid, out, 1, FIFO head valid toward downstream.
- out1, out, STREAMW, FIFO head data.
- oready, in, 1, downstream ready.
- count, out, CW, number of words popped so far.
- done, out, 1, sticky; set when NELEM words have been popped.
- overflow, out, 1, sticky; set when a word arrives while the FIFO is full and no pop occurs.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers, occupancy, count, done and overflow are cleared; iready=0.
  - ovalid=0 (FIFO empty); out1 is don't-care.
  - A reset asserted mid-operation discards all buffered data immediately.
- iready is registered.
  - First rising edge after reset release: iready becomes 1, provided DEPTH > SLACK.
  - Every edge: iready <= (DEPTH - occ_next) > SLACK, where occ_next is the occupancy after that edge's push/pop.
  - iready never depends combinationally on ivalid or oready.
- Push:
  - A word is written on every edge where ivalid=1 AND (occ < DEPTH OR pop in the same cycle).
  - iready is advisory to upstream. Arrivals while iready=0 are accepted while space exists; this is the slack contract.
- Pop: ovalid = (occ != 0), combinational from occupancy; out1 = mem[rd_ptr] (FWFT). A pop occurs when ovalid & oready.
- Simultaneous push and pop:
  - occ unchanged. Both pointers advance, wrapping modulo DEPTH.
  - When full, the push is accepted because the pop frees the slot in the same cycle.
  - When empty, no pop is possible (ovalid=0). The push lands and ovalid rises the next cycle.
- Overflow: ivalid=1, occ=DEPTH and no pop means the word is dropped, overflow <= 1 (sticky until reset), and pointers and occ are unchanged.
- Occupancy is an AW+1-bit register, range 0..DEPTH. Pointers are AW bits and wrap naturally.
- count: increments by 1 on each pop and saturates at 2^CW-1.
- done: set on the edge where count transitions to NELEM; sticky until reset. Pops after done are still served and counted.
- Latency:
  - ivalid to ovalid: 1 cycle when the FIFO is empty.
  - Pop to iready reassertion: 1 cycle.
- No combinational path from in1/ivalid to out1/ovalid.

Decomposition:
- Shared package:
  - STREAMW default.
  - The flopoco exception-field constant 2'b01.
  - The SLACK default, derived from the deepest kernel latency (8 for FPAdd).
- One natural sub-module, coriolis_fwft_fifo: storage plus pointers plus occupancy, with push/pop/full/empty/occ ports.
- The top level adds the slack-threshold iready register, counters, done and overflow.

Test Plan:
1. Release reset with ivalid=0 and oready=0: iready=0 during reset and 1 one edge after release; ovalid=0, count=0, done=0, overflow=0.
2. Push 34'h1_3F80_0000 with oready=1: ovalid=1 on the next cycle with out1=34'h1_3F80_0000; pop occurs and count=1.
3. Hold oready=0 and stream ivalid=1 continuously (DEPTH=16, SLACK=8): iready falls after the 8th accepted word, per the registered rule occ_next > DEPTH-SLACK-1. The remaining words up to 16 are accepted; the 17th word sets overflow=1 and is dropped; occ stays 16.
4. Full FIFO with ivalid=1 and oready=1 in the same cycle: occ stays 16, overflow stays 0, the head advances, and the data order is preserved (check against a scoreboard).
5. Set NELEM=4 and stream 5 words with oready=1: done rises on the edge of the 4th pop; count=5 after the 5th pop; done remains 1.
6. Assert rst low mid-stream with occ=6: ovalid=0, count=0 and iready=0 immediately and asynchronously; after release, the first pushed word appears at out1 with none of the stale data.
